btb_update_ctrl: RTL and testbench

Sequences all updates into the branch target buffer. Accepts resolved branches from the execute stage through a valid/ready handshake and buffers them in a small queue. Drains the queue into the BTB write port at one entry per cycle and reports mispredictions to fetch as a registered redirect. On a flush request it discards pending updates and sweeps an invalidate across every BTB index.

---
 rtl/btb_pkg.sv | 37 +++
 rtl/btb_update_ctrl_if.sv | 36 +++
 rtl/btb_update_fifo.sv | 79 +++++++
 rtl/btb_update_ctrl.sv | 151 +++++++++++++++
 tb/tb_btb_update_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared types and helpers for the BTB update controller.
//   buc_state_e     : controller state (RUN drains the queue, SWEEP invalidates the BTB)
//   res_entry_t     : one queued resolution {pc, taken, target}
//   PC_STEP         : fall-through increment for a not-taken branch
//   is_mispredict   : compares resolved outcome against the fetch-time prediction
//   correct_next_pc : PC fetch must restart from after a mispredict
package btb_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        SWEEP = 1'b1
    } buc_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } res_entry_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // The predicted target only matters when the branch was actually taken.
    function automatic logic is_mispredict(input logic        taken,
                                           input logic [31:0] target,
                                           input logic        pred_taken,
                                           input logic [31:0] pred_target);
        return (taken != pred_taken) || (taken && (target != pred_target));
    endfunction

    // Fall-through wraps modulo 2^32.
    function automatic logic [31:0] correct_next_pc(input logic [31:0] pc,
                                                    input logic        taken,
                                                    input logic [31:0] target);
        return taken ? target : (pc + PC_STEP);
    endfunction

endpackage

// File: rtl/btb_update_ctrl_if.sv
// Resolution channel from the execute stage into the BTB update controller.
//   buc_res_valid/buc_res_ready : handshake, transfer on valid && ready at a clock edge
//   buc_res_pc/taken/target     : resolved branch
//   buc_res_pred_taken/target   : what fetch predicted for this branch
// master = execute stage, slave = update controller.
interface btb_update_ctrl_if;

    logic        buc_res_valid;
    logic        buc_res_ready;
    logic [31:0] buc_res_pc;
    logic        buc_res_taken;
    logic [31:0] buc_res_target;
    logic        buc_res_pred_taken;
    logic [31:0] buc_res_pred_target;

    modport master (
        output buc_res_valid,
        output buc_res_pc,
        output buc_res_taken,
        output buc_res_target,
        output buc_res_pred_taken,
        output buc_res_pred_target,
        input  buc_res_ready
    );

    modport slave (
        input  buc_res_valid,
        input  buc_res_pc,
        input  buc_res_taken,
        input  buc_res_target,
        input  buc_res_pred_taken,
        input  buc_res_pred_target,
        output buc_res_ready
    );

endinterface

// File: rtl/btb_update_fifo.sv
// Synchronous FIFO holding resolved branches until they are written to the BTB.
//   clk, rst_n         : clock, synchronous active-low reset (empties the queue)
//   clear              : drop every entry this edge (wins over push/pop)
//   push, push_data    : enqueue, ignored when full
//   pop, pop_data      : dequeue; pop_data shows the head combinationally
//   count, full, empty : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module btb_update_fifo
    import btb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter int  CNT_W   = $clog2(DEPTH) + 1,
    parameter type entry_t = res_entry_t
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues resolved branches, writes one per cycle into the
// BTB, raises a registered redirect on mispredict, and on flush sweeps an
// invalidate over every BTB index.
//   buc_clk, buc_reset          : clock, synchronous active-low reset
//   res_if (slave)              : resolution handshake from execute
//   buc_flush_req               : level request for a full BTB invalidate
//   buc_flush_busy              : sweep in progress
//   buc_redirect, _redirect_pc  : one-cycle mispredict pulse and correct next PC
//   buc_btb_write/_branch_taken/_new_pc/_data : BTB write port
//   buc_btb_invalidate/_index   : BTB invalidate strobe and index
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int INDEX_BITS  = 4
) (
    input  logic                  buc_clk,
    input  logic                  buc_reset,
    btb_update_ctrl_if.slave      res_if,
    input  logic                  buc_flush_req,
    output logic                  buc_flush_busy,
    output logic                  buc_redirect,
    output logic [31:0]           buc_redirect_pc,
    output logic                  buc_btb_write,
    output logic                  buc_btb_branch_taken,
    output logic [31:0]           buc_btb_new_pc,
    output logic [31:0]           buc_btb_data,
    output logic                  buc_btb_invalidate,
    output logic [INDEX_BITS-1:0] buc_btb_index
);

    localparam int                  CNT_W      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W-1:0]    DEPTH_C    = CNT_W'(QUEUE_DEPTH);
    localparam logic [INDEX_BITS:0] SWEEP_LAST = (INDEX_BITS + 1)'((1 << INDEX_BITS) - 1);

    buc_state_e          state_q, state_d;
    logic [INDEX_BITS:0] cnt_q, cnt_d;
    logic                redirect_q, redirect_d;
    logic [31:0]         redirect_pc_q, redirect_pc_d;

    logic                res_ready;
    logic                accept;
    logic                fifo_clear;
    logic                fifo_pop;
    res_entry_t          fifo_in;
    res_entry_t          fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    assign fifo_in = '{pc:     res_if.buc_res_pc,
                       taken:  res_if.buc_res_taken,
                       target: res_if.buc_res_target};

    btb_update_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .CNT_W   (CNT_W),
        .entry_t (res_entry_t)
    ) u_fifo (
        .clk       (buc_clk),
        .rst_n     (buc_reset),
        .clear     (fifo_clear),
        // full already blocks ready; kept here so the FIFO never sees an overflow push
        .push      (accept && !fifo_full),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign res_if.buc_res_ready = res_ready;
    assign buc_redirect         = redirect_q;
    assign buc_redirect_pc      = redirect_pc_q;

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        redirect_d           = 1'b0;
        redirect_pc_d        = redirect_pc_q;
        res_ready            = 1'b0;
        fifo_clear           = 1'b0;
        fifo_pop             = 1'b0;
        buc_flush_busy       = 1'b0;
        buc_btb_write        = 1'b0;
        buc_btb_branch_taken = 1'b0;
        buc_btb_new_pc       = '0;
        buc_btb_data         = '0;
        buc_btb_invalidate   = 1'b0;
        buc_btb_index        = '0;

        // All drive outputs stay quiet while reset is held so the BTB never
        // samples a write or invalidate on the reset edge.
        if (buc_reset) begin
            case (state_q)
                RUN: begin
                    // A pending flush closes the door so nothing new lands in a
                    // queue that is about to be discarded.
                    res_ready = (fifo_count < DEPTH_C) && !buc_flush_req;
                    if (buc_flush_req) begin
                        fifo_clear = 1'b1;
                        state_d    = SWEEP;
                        cnt_d      = '0;
                    end else if (!fifo_empty) begin
                        buc_btb_write        = 1'b1;
                        buc_btb_branch_taken = fifo_head.taken;
                        buc_btb_new_pc       = fifo_head.pc;
                        buc_btb_data         = fifo_head.target;
                        fifo_pop             = 1'b1;
                    end
                end
                SWEEP: begin
                    buc_flush_busy     = 1'b1;
                    buc_btb_invalidate = 1'b1;
                    buc_btb_index      = cnt_q[INDEX_BITS-1:0];
                    if (cnt_q == SWEEP_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + (INDEX_BITS + 1)'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end

        accept = res_if.buc_res_valid && res_ready;
        if (accept && is_mispredict(res_if.buc_res_taken, res_if.buc_res_target,
                                    res_if.buc_res_pred_taken, res_if.buc_res_pred_target)) begin
            redirect_d    = 1'b1;
            redirect_pc_d = correct_next_pc(res_if.buc_res_pc, res_if.buc_res_taken,
                                            res_if.buc_res_target);
        end
    end

    always_ff @(posedge buc_clk) begin
        if (!buc_reset) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: a per-cycle vector table for the update and
// redirect path, then hand-written sequences for streaming, flush, held flush and
// reset in the middle of a sweep.
module tb_btb_update_ctrl;
    import btb_pkg::*;

    localparam int QD = 4;
    localparam int IB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          busy;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          btb_write;
    logic          btb_taken;
    logic [31:0]   btb_new_pc;
    logic [31:0]   btb_data;
    logic          btb_inv;
    logic [IB-1:0] btb_idx;

    int checks = 0;
    int failures = 0;

    btb_update_ctrl_if res_if ();

    btb_update_ctrl #(
        .QUEUE_DEPTH (QD),
        .INDEX_BITS  (IB)
    ) dut (
        .buc_clk              (clk),
        .buc_reset            (rst_n),
        .res_if               (res_if),
        .buc_flush_req        (flush),
        .buc_flush_busy       (busy),
        .buc_redirect         (redirect),
        .buc_redirect_pc      (redirect_pc),
        .buc_btb_write        (btb_write),
        .buc_btb_branch_taken (btb_taken),
        .buc_btb_new_pc       (btb_new_pc),
        .buc_btb_data         (btb_data),
        .buc_btb_invalidate   (btb_inv),
        .buc_btb_index        (btb_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        exp_ready;
        logic        exp_write;
        logic        exp_taken;
        logic [31:0] exp_new_pc;
        logic [31:0] exp_data;
        logic        exp_redirect;
        logic [31:0] exp_redirect_pc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tg, input logic pt, input logic [31:0] ptg,
                         input logic fl);
        res_if.buc_res_valid       = v;
        res_if.buc_res_pc          = pc;
        res_if.buc_res_taken       = tk;
        res_if.buc_res_target      = tg;
        res_if.buc_res_pred_taken  = pt;
        res_if.buc_res_pred_target = ptg;
        flush                      = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_btb(input string tag, input logic w, input logic tk,
                           input logic [31:0] pc, input logic [31:0] data);
        chk({tag, ".write"}, 32'(btb_write), 32'(w));
        chk({tag, ".taken"}, 32'(btb_taken), 32'(tk));
        chk({tag, ".new_pc"}, btb_new_pc, pc);
        chk({tag, ".data"}, btb_data, data);
    endtask

    task automatic chk_sweep(input string tag, input logic inv, input logic [IB-1:0] idx,
                             input logic bsy, input logic rdy);
        chk({tag, ".invalidate"}, 32'(btb_inv), 32'(inv));
        chk({tag, ".index"}, 32'(btb_idx), 32'(idx));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".ready"}, 32'(res_if.buc_res_ready), 32'(rdy));
    endtask

    initial begin
        // valid pc taken target pred_taken pred_target | ready write taken new_pc data redirect redirect_pc
        vecs[0] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h4,        1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF,
                    1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,
                    1'b1, 1'b1, 1'b1, 32'h4,        32'hDEADBEEF, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 32'h10,       1'b0, 32'h100,      1'b1, 32'h200,
                    1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
        vecs[4] = '{1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,        1'b1, 32'h300,
                    1'b1, 1'b1, 1'b0, 32'h10,       32'h100,      1'b1, 32'h14};
        vecs[5] = '{1'b1, 32'h20,       1'b1, 32'h80,       1'b1, 32'h84,
                    1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};
        vecs[6] = '{1'b1, 32'h30,       1'b1, 32'h40,       1'b0, 32'h40,
                    1'b1, 1'b1, 1'b1, 32'h20,       32'h80,       1'b1, 32'h80};
        vecs[7] = '{1'b1, 32'h50,       1'b0, 32'h0,        1'b0, 32'h99,
                    1'b1, 1'b1, 1'b1, 32'h30,       32'h40,       1'b1, 32'h40};
        vecs[8] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,
                    1'b1, 1'b1, 1'b0, 32'h50,       32'h0,        1'b0, 32'h40};
        vecs[9] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h40};

        // Reset
        drive(1'b1, 32'h8, 1'b1, 32'h8, 1'b0, 32'h0, 1'b0);
        next_cycle();
        next_cycle();
        chk("rst.ready", 32'(res_if.buc_res_ready), 32'd0);
        chk_btb("rst", 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rst.redirect", 32'(redirect), 32'd0);
        chk("rst.redirect_pc", redirect_pc, 32'h0);
        chk_sweep("rst", 1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Vector table, one entry per cycle
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].pc, vecs[i].taken, vecs[i].target,
                  vecs[i].pred_taken, vecs[i].pred_target, 1'b0);
            #1;
            chk($sformatf("vec%0d.ready", i), 32'(res_if.buc_res_ready), 32'(vecs[i].exp_ready));
            chk_btb($sformatf("vec%0d", i), vecs[i].exp_write, vecs[i].exp_taken,
                    vecs[i].exp_new_pc, vecs[i].exp_data);
            chk($sformatf("vec%0d.redirect", i), 32'(redirect), 32'(vecs[i].exp_redirect));
            chk($sformatf("vec%0d.redirect_pc", i), redirect_pc, vecs[i].exp_redirect_pc);
            next_cycle();
        end

        // Six back-to-back updates with simultaneous drain
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), i[0], 32'h1000 + 32'(i), i[0],
                  32'h1000 + 32'(i), 1'b0);
            #1;
            chk($sformatf("stream%0d.ready", i), 32'(res_if.buc_res_ready), 32'd1);
            if (i > 0)
                chk_btb($sformatf("stream%0d", i), 1'b1, (i - 1) % 2 == 1,
                        32'h100 + 32'((i - 1) * 4), 32'h1000 + 32'(i - 1));
            chk($sformatf("stream%0d.redirect", i), 32'(redirect), 32'd0);
            next_cycle();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_btb("stream_last", 1'b1, 1'b1, 32'h114, 32'h1005);
        next_cycle();
        chk_btb("stream_idle", 1'b0, 1'b0, 32'h0, 32'h0);

        // Flush with entries in flight: the last queued entry must never be written
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i * 4), 1'b1, 32'h2000 + 32'(i), 1'b1,
                  32'h2000 + 32'(i), 1'b0);
            next_cycle();
        end
        drive(1'b1, 32'h20C, 1'b1, 32'h3000, 1'b1, 32'h3000, 1'b1);
        #1;
        chk_btb("flush_edge", 1'b0, 1'b0, 32'h0, 32'h0);
        chk_sweep("flush_edge", 1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        for (int s = 0; s < 16; s++) begin
            drive(1'b1, 32'h210, 1'b1, 32'h3000, 1'b1, 32'h3000, 1'b0);
            #1;
            chk_sweep($sformatf("sweep%0d", s), 1'b1, IB'(s), 1'b1, 1'b0);
            chk($sformatf("sweep%0d.write", s), 32'(btb_write), 32'd0);
            next_cycle();
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk_sweep("post_sweep", 1'b0, '0, 1'b0, 1'b1);
        chk_btb("post_sweep", 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        chk_btb("post_sweep2", 1'b0, 1'b0, 32'h0, 32'h0);

        // Flush held high through the whole sweep
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        next_cycle();
        for (int s = 0; s < 16; s++) begin
            #1;
            chk_sweep($sformatf("held%0d", s), 1'b1, IB'(s), 1'b1, 1'b0);
            next_cycle();
        end
        #1;
        chk_sweep("held_gap", 1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        flush = 1'b0;
        for (int s = 0; s < 16; s++) begin
            #1;
            chk_sweep($sformatf("second%0d", s), 1'b1, IB'(s), 1'b1, 1'b0);
            next_cycle();
        end
        #1;
        chk_sweep("second_done", 1'b0, '0, 1'b0, 1'b1);

        // Reset at sweep index 7
        next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        for (int s = 0; s < 8; s++) begin
            #1;
            chk($sformatf("rsweep%0d.index", s), 32'(btb_idx), 32'(s));
            if (s < 7) next_cycle();
        end
        rst_n = 1'b0;
        #1;
        chk_sweep("rsweep_hold", 1'b0, '0, 1'b0, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk_sweep("rsweep_rel", 1'b0, '0, 1'b0, 1'b1);
        chk_btb("rsweep_rel", 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset with a queued entry and a pending redirect
        next_cycle();
        drive(1'b1, 32'h60, 1'b1, 32'h70, 1'b0, 32'h70, 1'b0);
        #1;
        chk("rq.ready", 32'(res_if.buc_res_ready), 32'd1);
        next_cycle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("rq.redirect", 32'(redirect), 32'd1);
        chk("rq.redirect_pc", redirect_pc, 32'h70);
        rst_n = 1'b0;
        #1;
        chk_btb("rq_hold", 1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("rq_rel.redirect", 32'(redirect), 32'd0);
        chk("rq_rel.redirect_pc", redirect_pc, 32'h0);
        chk_btb("rq_rel", 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rq_rel.ready", 32'(res_if.buc_res_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
